// File: rtl/clk_mon_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | clk_mon_pkg : shared constants and state encoding for clk_edge_monitor       |
// | Revision    : 1.0                                                            |
// +-----------------------------------------------------------------------------+
package clk_mon_pkg;

  localparam int C_CNT_W       = 16;
  localparam int C_SYNC_STAGES = 2;
  localparam int C_FILT_LEN    = 3;

  localparam logic [C_CNT_W-1:0] C_CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } mon_state_e;

  // Plain-vector encodings of the enum for register-level use.
  localparam logic [1:0] C_ST_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] C_ST_HIGH = 2'(ST_HIGH);
  localparam logic [1:0] C_ST_LOW  = 2'(ST_LOW);

endpackage
`default_nettype wire

// File: rtl/clk_mon_sync.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | clk_mon_sync : synchronizer, optional glitch filter, and edge detector       |
// | Optional     : GLITCH_FILTER_EN enables the FILT_LEN-sample level filter     |
// | Revision     : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module clk_mon_sync
  import clk_mon_pkg::*;
#(
  parameter int SYNC_STAGES = C_SYNC_STAGES,
  parameter int FILT_LEN    = C_FILT_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_param_check
    $error("clk_mon_sync: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sig_s;
  logic                   w_level;
  logic                   r_sig_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign w_sig_s = r_sync[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
  localparam int FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FCNT_W-1:0] C_FILT_LAST = FCNT_W'(FILT_LEN - 1);
  localparam logic [FCNT_W-1:0] C_FONE      = FCNT_W'(1);

  logic              r_acc;
  logic [FCNT_W-1:0] r_fcnt;

  // Any sample agreeing with the accepted level restarts the run count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= 1'b0;
      r_fcnt <= '0;
    end else if (w_sig_s != r_acc) begin
      if (r_fcnt == C_FILT_LAST) begin
        r_acc  <= w_sig_s;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + C_FONE;
      end
    end else begin
      r_fcnt <= '0;
    end
  end

  assign w_level = r_acc;
`else
  assign w_level = w_sig_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_d <= 1'b0;
    end else begin
      r_sig_d <= w_level;
    end
  end

  assign level = w_level;
  assign rise  = w_level & ~r_sig_d;
  assign fall  = ~w_level & r_sig_d;

endmodule
`default_nettype wire

// File: rtl/clk_edge_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | clk_edge_monitor : measures period and high time of an external square wave  |
// | Optional         : GLITCH_FILTER_EN (glitch filter inside clk_mon_sync)      |
// | Revision         : 1.0                                                       |
// +-----------------------------------------------------------------------------+
module clk_edge_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = C_CNT_W,
  parameter int SYNC_STAGES = C_SYNC_STAGES,
  parameter int FILT_LEN    = C_FILT_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clear,
  output logic             led_out,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] C_MAX = '1;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic             w_level;
  logic             w_rise;
  logic             w_fall;
  logic             w_active;
  logic [CNT_W-1:0] w_meas_high;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcap;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_timeout;
  logic             r_led;

  clk_mon_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .level  (w_level),
    .rise   (w_rise),
    .fall   (w_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= 1'b0;
    end else begin
      r_led <= w_level;
    end
  end

  assign w_active = (r_state == C_ST_HIGH) || (r_state == C_ST_LOW);
  // A rise while still HIGH means the fall was never seen: high time = whole period.
  assign w_meas_high = (r_state == C_ST_HIGH) ? r_cnt : r_hcap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= C_ST_IDLE;
      r_cnt     <= '0;
      r_hcap    <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (clear) begin
        r_state   <= C_ST_IDLE;
        r_cnt     <= '0;
        r_hcap    <= '0;
        r_period  <= '0;
        r_high    <= '0;
        r_timeout <= 1'b0;
      end else if (w_active && w_rise) begin
        // Measurement beats saturation when both land in the same cycle.
        r_period  <= r_cnt;
        r_high    <= w_meas_high;
        r_valid   <= 1'b1;
        r_timeout <= 1'b0;
        r_cnt     <= C_ONE;
        r_state   <= C_ST_HIGH;
      end else if (w_active && (r_cnt == C_MAX)) begin
        r_timeout <= 1'b1;
        r_cnt     <= '0;
        r_state   <= C_ST_IDLE;
      end else begin
        case (r_state)
          C_ST_IDLE: begin
            if (w_rise) begin
              r_cnt   <= C_ONE;
              r_state <= C_ST_HIGH;
            end
          end
          C_ST_HIGH: begin
            r_cnt <= r_cnt + C_ONE;
            if (w_fall) begin
              r_hcap  <= r_cnt;
              r_state <= C_ST_LOW;
            end
          end
          C_ST_LOW: begin
            r_cnt <= r_cnt + C_ONE;
          end
          default: begin
            r_cnt   <= '0;
            r_state <= C_ST_IDLE;
          end
        endcase
      end
    end
  end

  assign led_out    = r_led;
  assign period     = r_period;
  assign high_time  = r_high;
  assign meas_valid = r_valid;
  assign timeout    = r_timeout;
  assign busy       = (r_state != C_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clk_edge_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_clk_edge_monitor : scoreboard bench for clk_edge_monitor                  |
// | Revision            : 1.0                                                    |
// +-----------------------------------------------------------------------------+
module tb_clk_edge_monitor;

  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int FILT  = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef GLITCH_FILTER_EN
  localparam int LAT = SYNC + FILT;
`else
  localparam int LAT = SYNC;
`endif

  logic             clk;
  logic             rst_n;
  logic             sig_in;
  logic             clear;
  logic             led_out;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;
  logic             busy;

  clk_edge_monitor #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC),
    .FILT_LEN    (FILT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .clear      (clear),
    .led_out    (led_out),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] h;
  } meas_t;

  meas_t sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Reference model, stepped once per clk in the DUT's decision domain.
  logic [SYNC-1:0]  m_pipe;
  bit               m_prev, m_led, m_armed, m_hseen, m_to;
  int               m_dist, m_hi;
  logic [CNT_W-1:0] m_period, m_high;
`ifdef GLITCH_FILTER_EN
  bit               m_acc;
  int               m_fcnt;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pipe = '0; m_prev = 0; m_led = 0; m_armed = 0; m_hseen = 0; m_to = 0;
    m_dist = 0; m_hi = 0; m_period = '0; m_high = '0;
`ifdef GLITCH_FILTER_EN
    m_acc = 0; m_fcnt = 0;
`endif
  endtask

  task automatic model_step(input logic lvl, input logic clr);
    bit s, lv, rise, fall;
    meas_t m;
    s = m_pipe[SYNC-1];
    m_pipe = {m_pipe[SYNC-2:0], lvl};
`ifdef GLITCH_FILTER_EN
    lv = m_acc;
    if (s != m_acc) begin
      if (m_fcnt == FILT - 1) begin m_acc = s; m_fcnt = 0; end
      else m_fcnt++;
    end else m_fcnt = 0;
`else
    lv = s;
`endif
    rise = lv & ~m_prev;
    fall = ~lv & m_prev;
    m_prev = lv;
    m_led = lv;
    if (clr) begin
      m_armed = 0; m_dist = 0; m_hseen = 0;
      m_period = '0; m_high = '0; m_to = 0;
    end else if (m_armed) begin
      m_dist++;
      if (rise) begin
        m.p = CNT_W'(m_dist);
        m.h = m_hseen ? CNT_W'(m_hi) : CNT_W'(m_dist);
        sb_q.push_back(m);
        m_period = m.p; m_high = m.h; m_to = 0;
        m_dist = 0; m_hseen = 0;
      end else if (m_dist == CMAX) begin
        m_armed = 0; m_to = 1; m_dist = 0;
      end else if (fall) begin
        m_hi = m_dist; m_hseen = 1;
      end
    end else if (rise) begin
      m_armed = 1; m_dist = 0; m_hseen = 0;
    end
  endtask

  task automatic compare_outputs();
    meas_t m;
    check("meas_valid", meas_valid, sb_q.size() != 0);
    if (sb_q.size() != 0) begin
      m = sb_q.pop_front();
      if (meas_valid) begin
        check("meas_period", period, m.p);
        check("meas_high_time", high_time, m.h);
      end
    end
    check("period", period, m_period);
    check("high_time", high_time, m_high);
    check("timeout", timeout, m_to);
    check("busy", busy, m_armed);
    check("led_out", led_out, m_led);
  endtask

  task automatic drive(input logic lvl, input logic clr);
    sig_in = lvl;
    clear  = clr;
    @(posedge clk);
    model_step(lvl, clr);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      repeat (hi) drive(1'b1, 1'b0);
      repeat (lo) drive(1'b0, 1'b0);
    end
  endtask

  // 100-cycle wave with a 2-cycle dropout in the high phase and a 2-cycle spike in the low phase.
  task automatic glitch_wave(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (20) drive(1'b1, 1'b0);
      repeat (2)  drive(1'b0, 1'b0);
      repeat (28) drive(1'b1, 1'b0);
      repeat (25) drive(1'b0, 1'b0);
      repeat (2)  drive(1'b1, 1'b0);
      repeat (23) drive(1'b0, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_high_time"}, high_time, 0);
    check({tag, "_meas_valid"}, meas_valid, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_led_out"}, led_out, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    clear  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // 100/50 clean wave
    wave(50, 50, 4);
    // duty extremes at period 37
    wave(1, 36, 4);
    wave(36, 1, 4);

    // stall low until saturation, then recover; 255-cycle period hits the boundary
    repeat (300) drive(1'b0, 1'b0);
    wave(5, 250, 2);
    wave(20, 20, 2);

    // clear coinciding with the measuring rise as the FSM sees it
    wave(10, 10, 2);
    repeat (LAT) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    check("clear_busy", busy, 0);
    check("clear_period", period, 0);
    repeat (9) drive(1'b1, 1'b0);
    repeat (10) drive(1'b0, 1'b0);
    wave(10, 10, 2);

    // asynchronous reset in the middle of a LOW phase
    wave(30, 30, 2);
    repeat (10) drive(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    sig_in = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wave(30, 30, 3);

    // glitches on a 100/50 wave
    wave(50, 50, 1);
    glitch_wave(3);
    wave(50, 50, 2);
    repeat (20) drive(1'b0, 1'b0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_edge_monitor.md
Name: clk_edge_monitor

Overview:
- Receive-side companion to the team's clock-source / NAND-inverter / LED indicator netlists.
- Samples an external square wave such as a clock-generator output and measures its period and high time in units of the local clock.
- Reports each measurement with a one-cycle valid pulse.
- Provides a synchronized LED echo of the input, plus a timeout flag when the input stalls.
- Sits between a test-stimulus source and the multiplier bench as a sanity and health monitor.

Parameters:
- CNT_W, 16: width of the period, high-time and internal counters.
- SYNC_STAGES, 2: synchronizer flop count on sig_in; minimum 2.
- FILT_LEN, 3: consecutive equal samples required to accept a level change. Used only with GLITCH_FILTER_EN.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sig_in  in  1  asynchronous waveform under measurement.
- clear  in  1  synchronous; aborts the measurement and returns to IDLE.
- led_out  out  1  synchronized (and filtered, if enabled) copy of sig_in.
- period  out  CNT_W  last measured rising-to-rising interval, in clk cycles.
- high_time  out  CNT_W  last measured rising-to-falling interval, in clk cycles.
- meas_valid  out  1  one-cycle pulse when period and high_time update.
- timeout  out  1  sticky flag; input stalled past the counter range.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: all outputs are 0, FSM is IDLE, counters are 0, and synchronizer flops are 0.
- Conditioning: sig_s is sig_in after SYNC_STAGES flops. The filter (optional) acts on sig_s. sig_d is the 1-cycle delayed sig_s.
  - rise = sig_s & ~sig_d; fall = ~sig_s & sig_d.
  - led_out = sig_s, registered.
- Latency: sig_in edge to rise is SYNC_STAGES cycles. meas_valid, period and high_time update 1 cycle after the rise cycle.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: on rise, cnt is set to 1 and the FSM goes to HIGH. No measurement is output for the first edge.
  - HIGH: cnt increments every cycle. On fall, hcap is set to cnt and the FSM goes to LOW. If rise occurs without a fall, which cannot happen with a clean signal, it is treated as in LOW with hcap = cnt.
  - LOW: cnt increments. On rise:
    - period is set to cnt and high_time to hcap;
    - meas_valid pulses and timeout clears;
    - cnt is set to 1 and the FSM goes to HIGH.
- Period definition: period is the exact number of clk cycles between consecutive rise cycles. high_time is the number of cycles from rise to fall.
- Saturation and timeout: if cnt reaches 2^CNT_W-1 in HIGH or LOW, timeout is set and the FSM goes to IDLE.
  - period and high_time hold their last values.
  - timeout stays set until the next meas_valid, clear, or reset.
- clear: the FSM goes to IDLE, cnt is set to 0, and period, high_time and timeout are set to 0. No pulse is generated.
  - clear takes priority over a simultaneous rise, fall or saturation.
  - led_out keeps tracking the input during clear.
- Simultaneous saturation and rise in LOW: the measurement wins. period = 2^CNT_W-1 and meas_valid pulses; timeout is not set.
- Constant input (stuck at 0 or 1): the FSM stays in IDLE after the first timeout and re-arms on the next rise.
- Reset mid-measurement: the measurement is discarded immediately (asynchronous) and nothing is emitted.

Optional Feature:
- Macro: GLITCH_FILTER_EN.
- Defined: the accepted level changes only after FILT_LEN consecutive sig_s samples differ from the current accepted level.
  - Shorter pulses are ignored.
  - Added latency is FILT_LEN cycles, applied to both edges, so period and high_time are unchanged for clean inputs.
- Undefined: no filter; accepted level = sig_s; FILT_LEN is unused.

Decomposition:
- Package clk_mon_pkg:
  - state enum {IDLE, HIGH, LOW};
  - default CNT_W, SYNC_STAGES and FILT_LEN constants;
  - CNT_MAX = 2^CNT_W-1.
- Sub-module clk_mon_sync:
  - contains the synchronizer, the optional filter and the edge detector;
  - outputs level, rise and fall.
- The top level holds the FSM, counters and output registers.

Test Plan:
- Input with period 100 cycles and 50 high, clk-synchronous: after the 2nd rising edge, meas_valid pulses with period=100 and high_time=50. The same values repeat every 100 cycles.
- Duty sweep with period 37 and high 1, then high 36: high_time=1 and high_time=36 respectively, period=37. No missed pulses at the extremes.
- CNT_W=8 with sig_in held low after one rise: after 255 cycles, timeout=1, busy=0, and period holds its prior value. The next two rises give a valid measurement with timeout=0.
- clear asserted in the same cycle as the measuring rise: no meas_valid, period=0, high_time=0, FSM in IDLE, busy=0. The following rise re-arms the FSM.
- rst_n dropped mid-LOW, asynchronously between clk edges: outputs are 0 immediately; after release, the first rise produces no pulse.
- GLITCH_FILTER_EN with FILT_LEN=3 and 2-cycle glitches injected on a 100/50 wave: measurements stay at 100/50. Without the macro, the glitches corrupt the measured values.
